seg7_scan_driver: RTL and testbench

//   Output-side human interface: drives the 4-digit multiplexed common-anode 7-segment display.

---
 rtl/seg7_scan_driver_if.sv | 31 +++
 rtl/seg7_scan_driver.sv | 181 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Bus bundle between the display owner (CPU/top) and the 7-segment scan driver.
//   disp_data  : 16-bit hex value, [3:0]=digit0 (rightmost) .. [15:12]=digit3
//   point      : decimal point enables, bit i -> digit i, 1=on
//   blank      : per-digit blank, bit i=1 -> digit i dark
//   disp_load  : 1-cycle strobe capturing disp_data/point/blank into the shadow
//   blink_en   : live whole-display blink enable
//   an         : anode selects, active-low
//   seg        : segments active-low, [6:0]=gfedcba, [7]=dp
//   frame_tick : 1-cycle pulse when the digit index wraps 3->0
interface seg7_scan_driver_if;
  logic [15:0] disp_data;
  logic [3:0]  point;
  logic [3:0]  blank;
  logic        disp_load;
  logic        blink_en;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_tick;

  // Display owner side
  modport master (
    output disp_data, point, blank, disp_load, blink_en,
    input  an, seg, frame_tick
  );

  // Scan driver side
  modport slave (
    input  disp_data, point, blank, disp_load, blink_en,
    output an, seg, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed common-anode 7-segment scan driver.
// Scans digits at SCAN_DIV clocks per slot, decodes hex to segments, and
// swaps newly loaded data in only at frame boundaries so a frame never tears.
// Ports:
//   clk   : system clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : seg7_scan_driver_if.slave (load inputs in, an/seg/frame_tick out)
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_scan_driver_if.slave    bus
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  point;
    logic [3:0]  blank;
  } disp_t;

  // Hex digit to active-low gfedcba pattern
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_dig_idx;
  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_blink_ph;
  disp_t            r_shadow;
  disp_t            r_active;
  logic             r_pending;
  logic             r_lit;
  logic [3:0]       r_an;
  logic [7:0]       r_seg;
  logic             r_frame_tick;

  logic             w_slot_end;
  logic             w_frame_end;
  logic [1:0]       w_dig_next;
  logic             w_commit;
  disp_t            w_active_next;
  logic             w_lit_next;
  logic             w_blink_wrap;
  logic             w_ph_next;
  logic             w_dark;
  logic [3:0]       w_nibble;
  logic             w_dp_on;
  logic [3:0]       w_an_next;
  logic [7:0]       w_seg_next;

  // Slot / frame timing
  assign w_slot_end  = (r_div_cnt == DIV_LAST);
  assign w_frame_end = w_slot_end && (r_dig_idx == 2'd3);
  assign w_dig_next  = r_dig_idx + 2'd1;

  // Commit uses the shadow as it stood before this cycle's load, so a load
  // landing on the boundary waits one more frame.
  assign w_commit      = w_frame_end && r_pending;
  assign w_active_next = w_commit ? r_shadow : r_active;
  assign w_lit_next    = r_lit | w_commit;

  assign w_blink_wrap = w_frame_end && (r_blink_cnt == BLK_LAST);
  assign w_ph_next    = r_blink_ph ^ w_blink_wrap;

  // Select the digit about to be shown; outputs are loaded from these at slot end
  always_comb begin
    w_nibble = 4'h0;
    w_dp_on  = 1'b0;
    w_dark   = 1'b0;
    case (w_dig_next)
      2'd0: begin
        w_nibble = w_active_next.data[3:0];
        w_dp_on  = w_active_next.point[0];
        w_dark   = w_active_next.blank[0];
      end
      2'd1: begin
        w_nibble = w_active_next.data[7:4];
        w_dp_on  = w_active_next.point[1];
        w_dark   = w_active_next.blank[1];
      end
      2'd2: begin
        w_nibble = w_active_next.data[11:8];
        w_dp_on  = w_active_next.point[2];
        w_dark   = w_active_next.blank[2];
      end
      default: begin
        w_nibble = w_active_next.data[15:12];
        w_dp_on  = w_active_next.point[3];
        w_dark   = w_active_next.blank[3];
      end
    endcase
    if (bus.blink_en && w_ph_next) begin
      w_dark = 1'b1;
    end
  end

  // Next anode/segment pattern; segments stay dark until the first commit
  always_comb begin
    w_an_next  = 4'b1111;
    w_seg_next = 8'hFF;
    if (!w_dark) begin
      w_an_next = ~(4'b0001 << w_dig_next);
      if (w_lit_next) begin
        w_seg_next = {~w_dp_on, hex7(w_nibble)};
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt    <= '0;
      r_dig_idx    <= 2'd0;
      r_blink_cnt  <= '0;
      r_blink_ph   <= 1'b0;
      r_shadow     <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
      r_lit        <= 1'b0;
      r_an         <= 4'b1111;
      r_seg        <= 8'hFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_div_cnt    <= w_slot_end ? '0 : r_div_cnt + DIV_W'(1);
      r_frame_tick <= w_frame_end;

      if (w_slot_end) begin
        r_dig_idx <= w_dig_next;
        r_an      <= w_an_next;
        r_seg     <= w_seg_next;
      end

      if (w_frame_end) begin
        r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BLK_W'(1);
        r_blink_ph  <= w_ph_next;
        r_active    <= w_active_next;
        r_lit       <= w_lit_next;
      end

      // A new load always wins over clearing pending
      if (bus.disp_load) begin
        r_shadow  <= disp_t'{data: bus.disp_data, point: bus.point, blank: bus.blank};
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (SCAN_DIV=4, BLINK_FRAMES=2).
// Stimulus pushes hand-computed per-frame expectations; a monitor pops one
// per frame_tick and checks every digit slot of that frame.
module tb_seg7_scan_driver;

  logic clk;
  logic rst_n;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          frame;
    logic [15:0] an;   // {digit3..digit0} slot anodes
    logic [31:0] seg;  // {digit3..digit0} slot segments
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   onehot_viol = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_frame(input int f, input logic [15:0] an4, input logic [31:0] seg4);
    exp_t e;
    e.frame = f;
    e.an    = an4;
    e.seg   = seg4;
    q.push_back(e);
  endtask

  // Monitor: frame tracking and per-slot scoreboard compare
  int   frame_no = 0;
  int   cyc = 0;
  bit   seen_tick = 0;
  bit   cur_valid = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      frame_no  = 0;
      cyc       = 0;
      seen_tick = 0;
      cur_valid = 0;
    end else begin
      if (bus.frame_tick === 1'b1) begin
        if (seen_tick) chk($sformatf("frame_period_f%0d", frame_no + 1), 32'(cyc), 32'd15);
        frame_no++;
        cyc       = 0;
        seen_tick = 1;
        cur_valid = 0;
        while (q.size() > 0 && q[0].frame < frame_no) begin
          chk("frame_missed", 32'(q[0].frame), 32'(frame_no));
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].frame == frame_no) begin
          cur       = q.pop_front();
          cur_valid = 1;
        end
      end else begin
        cyc++;
      end
      if (cur_valid && cyc < 16 && (cyc % 4 == 0 || cyc % 4 == 3)) begin
        chk($sformatf("f%0d_c%0d_an", frame_no, cyc), 32'(bus.an), 32'(cur.an[(cyc/4)*4 +: 4]));
        chk($sformatf("f%0d_c%0d_seg", frame_no, cyc), 32'(bus.seg), 32'(cur.seg[(cyc/4)*8 +: 8]));
      end
    end
  end

  // Never more than one anode low
  always @(negedge clk) begin
    logic [3:0] lo;
    lo = ~bus.an;
    if (!(bus.an == 4'b1111 || $onehot(lo))) onehot_viol++;
  end

  // Wait for the negedge where frame_tick is seen, bounded
  task automatic wait_tick();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) return;
    end
    chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    bus.disp_data = d;
    bus.point     = p;
    bus.blank     = b;
    bus.disp_load = 1'b1;
    @(negedge clk);
    bus.disp_load = 1'b0;
  endtask

  localparam logic [15:0] AN_SCAN = 16'h7BDE;
  localparam logic [15:0] AN_DARK = 16'hFFFF;
  localparam logic [31:0] SEG_OFF = 32'hFFFFFFFF;

  initial begin
    rst_n         = 1'b0;
    bus.disp_data = 16'h0;
    bus.point     = 4'h0;
    bus.blank     = 4'h0;
    bus.disp_load = 1'b0;
    bus.blink_en  = 1'b0;

    // Reset and first lit slot
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'hFF);
    chk("rst_tick", 32'(bus.frame_tick), 32'h0);
    repeat (3) @(posedge clk);
    #1 chk("pre_slot_an", 32'(bus.an), 32'hF);
    @(posedge clk);
    #1 chk("first_slot_an", 32'(bus.an), 32'hD);
    chk("first_slot_seg", 32'(bus.seg), 32'hFF);
    push_frame(1, AN_SCAN, SEG_OFF);

    // Load during frame 1 shows from frame 2
    wait_tick();
    push_frame(2, AN_SCAN, 32'hF9A4888E);
    repeat (2) @(negedge clk);
    do_load(16'h12AF, 4'h0, 4'h0);

    // Two loads in one frame: last wins
    wait_tick();
    repeat (3) @(negedge clk);
    do_load(16'h1111, 4'h0, 4'h0);
    repeat (4) @(negedge clk);
    do_load(16'h2222, 4'h0, 4'h0);
    push_frame(3, AN_SCAN, 32'hA4A4A4A4);

    // Pending load commits, boundary-cycle load waits a frame
    wait_tick();
    repeat (5) @(negedge clk);
    do_load(16'h4444, 4'h0, 4'h0);
    push_frame(4, AN_SCAN, 32'h99999999);
    repeat (9) @(negedge clk);
    do_load(16'h5555, 4'h0, 4'h0);
    push_frame(5, AN_SCAN, 32'h92929292);

    // Decimal point on digit2, digit3 blanked
    wait_tick();
    repeat (2) @(negedge clk);
    do_load(16'h0123, 4'b0100, 4'b1000);
    push_frame(6, 16'hFBDE, 32'hFF79A4B0);
    push_frame(7, 16'hFBDE, 32'hFF79A4B0);

    // Blink: phase is dark on frames 10,11, lit on 8,9,12,13
    wait_tick();
    wait_tick();
    repeat (15) @(negedge clk);
    bus.blink_en = 1'b1;
    push_frame(8,  16'hFBDE, 32'hFF79A4B0);
    push_frame(9,  16'hFBDE, 32'hFF79A4B0);
    push_frame(10, AN_DARK,  SEG_OFF);
    push_frame(11, AN_DARK,  SEG_OFF);
    push_frame(12, 16'hFBDE, 32'hFF79A4B0);
    push_frame(13, 16'hFBDE, 32'hFF79A4B0);
    repeat (6) wait_tick();
    repeat (15) @(negedge clk);
    bus.blink_en = 1'b0;
    push_frame(14, 16'hFBDE, 32'hFF79A4B0);

    // Mid-slot reset with a load pending: pending data never appears
    wait_tick();
    repeat (3) @(negedge clk);
    do_load(16'hFFFF, 4'hF, 4'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 chk("midrst_an", 32'(bus.an), 32'hF);
    chk("midrst_seg", 32'(bus.seg), 32'hFF);
    chk("midrst_tick", 32'(bus.frame_tick), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(1, AN_SCAN, SEG_OFF);
    push_frame(2, AN_SCAN, SEG_OFF);
    repeat (3) wait_tick();

    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("onehot_an", 32'(onehot_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
